cmd_exec: RTL and testbench

Command executor for the Knight's Tour robot. It consumes the 16-bit command stream produced by the UART/tour command mux, decodes it, and handshakes back to the producer with `clr_cmd_rdy` and `send_resp`. It executes calibrate, move and move-with-fanfare commands: it sets the desired heading, ramps forward speed, counts board lines and decelerates to a stop. It sits between the command mux and the PID/inertial/motor blocks.

---
 rtl/tour_pkg.sv | 31 +++
 rtl/line_cntr.sv | 38 +++
 rtl/cmd_exec.sv | 172 +++++++++++++++++
 tb/tb_cmd_exec.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared definitions for the Knight's Tour command path: opcodes, compass
// headings, the executor state type and small heading helpers.
package tour_pkg;

  localparam logic [3:0] CMD_CAL     = 4'b0000;
  localparam logic [3:0] CMD_MOVE    = 4'b0010;
  localparam logic [3:0] CMD_MOVE_FF = 4'b0011;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAL       = 3'd1,
    TURN      = 3'd2,
    RAMP_UP   = 3'd3,
    RAMP_DOWN = 3'd4
  } state_t;

  // North stays exactly zero; other headings sit at the top of their 16-count bin.
  function automatic logic [11:0] expand_heading(input logic [7:0] h8);
    return (h8 == 8'h00) ? 12'h000 : {h8, 4'hF};
  endfunction

  function automatic logic [11:0] abs12(input logic [11:0] v);
    return v[11] ? (~v + 12'd1) : v;
  endfunction

endpackage

// File: rtl/line_cntr.sv
// Counts rising edges of the center line IR while enabled; clear has priority.
module line_cntr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cntr_ir,
  input  logic       en,
  input  logic       clr,
  output logic [4:0] cnt
);

  logic       cntr_ir_q;
  logic       cntr_ir_d;
  logic [4:0] cnt_q;
  logic [4:0] cnt_d;

  always_comb begin
    cntr_ir_d = cntr_ir;
    cnt_d     = cnt_q;
    if (clr) begin
      cnt_d = 5'd0;
    end else if (en && cntr_ir && !cntr_ir_q) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntr_ir_q <= 1'b0;
      cnt_q     <= 5'd0;
    end else begin
      cntr_ir_q <= cntr_ir_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cmd_exec.sv
// Knight's Tour command executor: decodes calibrate/move commands, steers the
// heading error, ramps forward speed across board lines and reports completion.
module cmd_exec
  import tour_pkg::*;
#(
  parameter bit          FAST_SIM   = 1'b1,
  parameter logic [11:0] ERR_THRESH = 12'h030,
  parameter logic [9:0]  MAX_FRWRD  = 10'h2A0,
  parameter logic [11:0] IR_NUDGE   = 12'h05F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic        strt_cal,
  input  logic        cal_done,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        lftIR,
  input  logic        rghtIR,
  input  logic        cntrIR,
  output logic [11:0] error,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        fanfare_go
);

  localparam logic [9:0]  STEP    = FAST_SIM ? 10'h020 : 10'h003;
  localparam logic [10:0] DN_STEP = {STEP, 1'b0};

  state_t      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [3:0]  squares_q, squares_d;
  logic [11:0] desired_q, desired_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic        send_resp_q, send_resp_d;
  logic        strt_cal_q, strt_cal_d;
  logic        fanfare_q, fanfare_d;

  logic        accept;
  logic        is_move_cmd;
  logic        is_cal_cmd;
  logic [4:0]  line_cnt;
  logic        at_target;
  logic [11:0] nudge;
  logic [10:0] up_sum;
  logic        ramping;

  // Handshake: cmd_rdy is a level held by the producer; in IDLE the command is
  // taken in the same cycle and clr_cmd_rdy is the one-cycle acknowledge.
  assign accept      = (state_q == IDLE) && cmd_rdy;
  assign is_move_cmd = (cmd[15:12] == CMD_MOVE) || (cmd[15:12] == CMD_MOVE_FF);
  assign is_cal_cmd  = (cmd[15:12] == CMD_CAL);
  assign at_target   = (line_cnt == {squares_q, 1'b0});
  assign ramping     = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  assign up_sum      = {1'b0, frwrd_q} + {1'b0, STEP};

  line_cntr u_line_cntr (
    .clk     (clk),
    .rst_n   (rst_n),
    .cntr_ir (cntrIR),
    .en      (state_q == RAMP_UP),
    .clr     (accept),
    .cnt     (line_cnt)
  );

  // Guard-rail nudge cancels out when both side IRs see the rail.
  always_comb begin
    nudge = 12'h000;
    if (ramping && lftIR && !rghtIR) begin
      nudge = IR_NUDGE;
    end else if (ramping && rghtIR && !lftIR) begin
      nudge = ~IR_NUDGE + 12'd1;
    end
  end

  assign error = heading - desired_q + nudge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          if (is_cal_cmd) begin
            state_d = CAL;
          end else if (is_move_cmd) begin
            state_d = TURN;
          end
        end
      end
      CAL: begin
        if (cal_done) state_d = IDLE;
      end
      TURN: begin
        if (heading_rdy && (abs12(error) < ERR_THRESH)) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (at_target) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (frwrd_q == 10'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_cmd_rdy = accept;
    moving      = (state_q == TURN) || ramping;
    strt_cal_d  = accept && is_cal_cmd;
    send_resp_d = (accept && !is_cal_cmd && !is_move_cmd)
                || ((state_q == CAL) && cal_done)
                || ((state_q == RAMP_DOWN) && (frwrd_q == 10'd0));
    fanfare_d   = (state_q == RAMP_DOWN) && (frwrd_q == 10'd0)
                && (opcode_q == CMD_MOVE_FF);
  end

  always_comb begin
    opcode_d  = opcode_q;
    squares_d = squares_q;
    desired_d = desired_q;
    frwrd_d   = frwrd_q;
    if (accept) begin
      opcode_d  = cmd[15:12];
      squares_d = cmd[3:0];
      frwrd_d   = 10'd0;
      if (is_move_cmd) desired_d = expand_heading(cmd[11:4]);
    end
    // Speed holds on the final ramp-up cycle so a zero-square move never moves.
    if ((state_q == RAMP_UP) && !at_target && heading_rdy) begin
      frwrd_d = (up_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : up_sum[9:0];
    end else if ((state_q == RAMP_DOWN) && heading_rdy) begin
      frwrd_d = ({1'b0, frwrd_q} <= DN_STEP) ? 10'd0 : (frwrd_q - DN_STEP[9:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q    <= 4'd0;
      squares_q   <= 4'd0;
      desired_q   <= 12'd0;
      frwrd_q     <= 10'd0;
      send_resp_q <= 1'b0;
      strt_cal_q  <= 1'b0;
      fanfare_q   <= 1'b0;
    end else begin
      opcode_q    <= opcode_d;
      squares_q   <= squares_d;
      desired_q   <= desired_d;
      frwrd_q     <= frwrd_d;
      send_resp_q <= send_resp_d;
      strt_cal_q  <= strt_cal_d;
      fanfare_q   <= fanfare_d;
    end
  end

  assign frwrd      = frwrd_q;
  assign send_resp  = send_resp_q;
  assign strt_cal   = strt_cal_q;
  assign fanfare_go = fanfare_q;

endmodule

// File: tb/tb_cmd_exec.sv
// Directed and randomized checks of cmd_exec against a speed/error model
// derived from the command rules (ramp arithmetic, heading error, handshakes).
module tb_cmd_exec;
  import tour_pkg::*;

  localparam logic [9:0] STEP = 10'h020;
  localparam logic [9:0] MAXF = 10'h2A0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0;
  logic        cmd_rdy = 1'b0;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        strt_cal;
  logic        cal_done = 1'b0;
  logic [11:0] heading = 12'h0;
  logic        heading_rdy = 1'b0;
  logic        lftIR = 1'b0;
  logic        rghtIR = 1'b0;
  logic        cntrIR = 1'b0;
  logic [11:0] error;
  logic [9:0]  frwrd;
  logic        moving;
  logic        fanfare_go;

  int checks = 0;
  int failures = 0;

  logic [11:0] cur_des;
  bit          cur_ff;

  cmd_exec dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .strt_cal    (strt_cal),
    .cal_done    (cal_done),
    .heading     (heading),
    .heading_rdy (heading_rdy),
    .lftIR       (lftIR),
    .rghtIR      (rghtIR),
    .cntrIR      (cntrIR),
    .error       (error),
    .frwrd       (frwrd),
    .moving      (moving),
    .fanfare_go  (fanfare_go)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [11:0] des_of(input logic [7:0] h8);
    logic [11:0] d;
    d = 12'h000;
    if (h8 != 8'h00) d = {h8, 4'hF};
    return d;
  endfunction

  function automatic logic [11:0] exp_err(input logic [11:0] h, input logic [11:0] d,
                                          input bit l, input bit r, input bit ramp);
    int nud;
    nud = 0;
    if (ramp && l && !r) nud = 'h5F;
    if (ramp && r && !l) nud = -'h5F;
    return 12'(int'(h) - int'(d) + nud);
  endfunction

  function automatic logic [9:0] sat_up(input int n);
    int v;
    v = n * int'(STEP);
    if (v > int'(MAXF)) v = int'(MAXF);
    return 10'(v);
  endfunction

  function automatic logic [9:0] sat_dn(input logic [9:0] peak, input int k);
    int v;
    v = int'(peak) - k * 2 * int'(STEP);
    if (v < 0) v = 0;
    return 10'(v);
  endfunction

  function automatic logic [11:0] near(input logic [11:0] d);
    int off;
    off = int'($urandom_range(0, 94)) - 47;
    return d + 12'(off);
  endfunction

  task automatic accept_cmd(input logic [15:0] c);
    cur_des = des_of(c[11:4]);
    cur_ff  = (c[15:12] == CMD_MOVE_FF);
    cmd     = c;
    cmd_rdy = 1'b1;
    smp();
    check("clr_same_cycle", clr_cmd_rdy, 1);
    check("idle_not_moving", moving, 0);
    cyc();
    cmd_rdy = 1'b0;
  endtask

  // One TURN cycle with heading inside the threshold; side IRs must not nudge.
  task automatic turn_exit(input bit exact);
    heading     = exact ? cur_des : near(cur_des);
    lftIR       = 1'($urandom_range(0, 1));
    rghtIR      = 1'($urandom_range(0, 1));
    heading_rdy = 1'b1;
    smp();
    check("turn_moving", moving, 1);
    check("turn_frwrd", frwrd, 0);
    check("turn_error", error, exp_err(heading, cur_des, lftIR, rghtIR, 1'b0));
    check("turn_clr", clr_cmd_rdy, 0);
    cyc();
    heading_rdy = 1'b0;
    lftIR       = 1'b0;
    rghtIR      = 1'b0;
  endtask

  task automatic ramp_finish(input int n0, input int up_cycles, input bit all_hr, input int sq,
                             input bit rnd_ir, input bit pend, input logic [15:0] pcmd);
    int n;
    int k;
    int z;
    bit done;
    logic [9:0] peak;
    logic [9:0] exp_f;
    n = n0;
    done = 1'b0;
    if (pend) begin
      cmd = pcmd;
      cmd_rdy = 1'b1;
    end
    if (sq == 0) begin
      for (int i = 0; i < 3; i++) begin
        heading_rdy = 1'($urandom_range(0, 1));
        smp();
        check("sq0_frwrd", frwrd, 0);
        check("sq0_resp", send_resp, (i == 2));
        check("sq0_fanfare", fanfare_go, (i == 2) && cur_ff);
        check("sq0_moving", moving, (i < 2));
        check("sq0_clr", clr_cmd_rdy, pend && (i == 2));
        cyc();
      end
      done = 1'b1;
    end else begin
      for (int i = 0; i < up_cycles; i++) begin
        heading_rdy = (all_hr || i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        heading     = 12'($urandom);
        lftIR       = rnd_ir ? 1'($urandom_range(0, 1)) : 1'b0;
        rghtIR      = rnd_ir ? 1'($urandom_range(0, 1)) : 1'b0;
        smp();
        check("up_frwrd", frwrd, sat_up(n));
        check("up_error", error, exp_err(heading, cur_des, lftIR, rghtIR, 1'b1));
        check("up_resp", send_resp, 0);
        check("up_clr_pending", clr_cmd_rdy, 0);
        if (heading_rdy) n++;
        cyc();
      end
      heading_rdy = 1'b0;
      lftIR = 1'b0;
      rghtIR = 1'b0;
      for (int e = 0; e < 2 * sq; e++) begin
        cntrIR = 1'b1;
        smp();
        check("edge_frwrd_hi", frwrd, sat_up(n));
        cyc();
        cntrIR = 1'b0;
        smp();
        check("edge_frwrd_lo", frwrd, sat_up(n));
        cyc();
      end
      peak = sat_up(n);
      k = 0;
      z = -1;
      for (int i = 0; i < 300 && !done; i++) begin
        heading_rdy = 1'($urandom_range(0, 1));
        heading     = 12'($urandom);
        lftIR       = rnd_ir ? 1'($urandom_range(0, 1)) : 1'b0;
        rghtIR      = rnd_ir ? 1'($urandom_range(0, 1)) : 1'b0;
        smp();
        exp_f = sat_dn(peak, k);
        if (exp_f == 10'd0 && z < 0) z = i;
        check("dn_frwrd", frwrd, exp_f);
        check("dn_resp", send_resp, (z >= 0) && (i == z + 1));
        check("dn_fanfare", fanfare_go, (z >= 0) && (i == z + 1) && cur_ff);
        check("dn_clr_pending", clr_cmd_rdy, pend && (z >= 0) && (i == z + 1));
        if ((z >= 0) && (i == z + 1)) begin
          check("dn_idle_moving", moving, 0);
          done = 1'b1;
        end else begin
          check("dn_error", error, exp_err(heading, cur_des, lftIR, rghtIR, 1'b1));
          if (heading_rdy && exp_f != 10'd0) k++;
        end
        cyc();
      end
    end
    heading_rdy = 1'b0;
    lftIR = 1'b0;
    rghtIR = 1'b0;
    if (!done) check("ramp_down_timeout", 0, 1);
    if (pend) begin
      cmd_rdy = 1'b0;
      cur_des = des_of(pcmd[11:4]);
      cur_ff  = (pcmd[15:12] == CMD_MOVE_FF);
    end
    smp();
    check("resp_one_cycle", send_resp, 0);
    check("fanfare_one_cycle", fanfare_go, 0);
    cyc();
  endtask

  initial begin
    int strt_cnt;
    logic [7:0] hb;
    logic [3:0] op;

    // Reset
    for (int i = 0; i < 3; i++) cyc();
    smp();
    check("rst_frwrd", frwrd, 0);
    check("rst_moving", moving, 0);
    check("rst_error", error, 0);
    check("rst_send_resp", send_resp, 0);
    check("rst_strt_cal", strt_cal, 0);
    check("rst_fanfare", fanfare_go, 0);
    check("rst_clr", clr_cmd_rdy, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Calibrate: one strt_cal pulse, response the cycle after cal_done
    accept_cmd(16'h0000);
    strt_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cal_done = (i == 9);
      smp();
      if (strt_cal) strt_cnt++;
      check("cal_resp", send_resp, (i == 10));
      check("cal_moving", moving, 0);
      check("cal_fanfare", fanfare_go, 0);
      cyc();
    end
    cal_done = 1'b0;
    check("cal_strt_pulses", strt_cnt, 1);

    // Move north two squares: full saturation then ramp down
    heading = 12'h000;
    accept_cmd(16'h2002);
    smp();
    check("north_error_turn", error, 0);
    cyc();
    turn_exit(1'b1);
    ramp_finish(0, 26, 1'b1, 2, 1'b0, 1'b0, 16'h0);

    // Move south with fanfare: threshold boundary and IR nudges
    heading = 12'h000;
    accept_cmd(16'h37F1);
    smp();
    check("south_err_801", error, 12'h801);
    cyc();
    heading = 12'h7CF;
    heading_rdy = 1'b1;
    smp();
    check("err_at_thresh", error, 12'hFD0);
    cyc();
    smp();
    check("no_ramp_at_thresh", frwrd, 0);
    cyc();
    heading_rdy = 1'b0;
    lftIR = 1'b1;
    smp();
    check("no_nudge_in_turn", error, 12'hFD0);
    check("still_turn_frwrd", frwrd, 0);
    cyc();
    lftIR = 1'b0;
    heading = 12'h7D0;
    heading_rdy = 1'b1;
    smp();
    cyc();
    heading = 12'h7FF;
    smp();
    check("ramp_entry_frwrd", frwrd, 0);
    cyc();
    heading_rdy = 1'b0;
    lftIR = 1'b1;
    smp();
    check("first_ramp_step", frwrd, 10'h020);
    check("nudge_left", error, 12'h05F);
    cyc();
    rghtIR = 1'b1;
    smp();
    check("nudge_both", error, 12'h000);
    cyc();
    lftIR = 1'b0;
    smp();
    check("nudge_right", error, 12'hFA1);
    cyc();
    rghtIR = 1'b0;
    ramp_finish(1, 4, 1'b0, 1, 1'b0, 1'b0, 16'h0);

    // Command pending during a move is acknowledged when IDLE is re-entered
    heading = 12'h000;
    accept_cmd(16'h2001);
    turn_exit(1'b0);
    ramp_finish(0, 6, 1'b0, 1, 1'b1, 1'b1, {CMD_MOVE_FF, EAST, 4'd2});
    turn_exit(1'b0);
    ramp_finish(0, 8, 1'b0, 2, 1'b1, 1'b0, 16'h0);

    // Unknown opcode: acknowledge, then respond next cycle
    cmd = 16'hF123;
    cmd_rdy = 1'b1;
    smp();
    check("unk_clr", clr_cmd_rdy, 1);
    check("unk_resp_early", send_resp, 0);
    cyc();
    cmd_rdy = 1'b0;
    smp();
    check("unk_resp", send_resp, 1);
    check("unk_moving", moving, 0);
    check("unk_fanfare", fanfare_go, 0);
    cyc();
    smp();
    check("unk_resp_width", send_resp, 0);
    cyc();

    // Asynchronous reset in the middle of a ramp
    heading = 12'h000;
    accept_cmd(16'h2001);
    turn_exit(1'b1);
    heading_rdy = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    heading_rdy = 1'b0;
    smp();
    check("pre_reset_frwrd", frwrd, 10'h100);
    check("pre_reset_moving", moving, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_frwrd", frwrd, 0);
    check("async_rst_moving", moving, 0);
    check("async_rst_error", error, 0);
    check("async_rst_resp", send_resp, 0);
    check("async_rst_strt", strt_cal, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      smp();
      check("rst_hold_resp", send_resp, 0);
      check("rst_hold_frwrd", frwrd, 0);
      cyc();
    end
    rst_n = 1'b1;
    cyc();
    accept_cmd(16'h2001);
    turn_exit(1'b0);
    ramp_finish(0, 10, 1'b0, 1, 1'b1, 1'b0, 16'h0);

    // Randomized moves
    for (int m = 0; m < 8; m++) begin
      case ($urandom_range(0, 4))
        0: hb = NORTH;
        1: hb = WEST;
        2: hb = SOUTH;
        3: hb = EAST;
        default: hb = 8'($urandom);
      endcase
      op = ($urandom_range(0, 1) == 0) ? CMD_MOVE : CMD_MOVE_FF;
      begin
        int sq;
        sq = int'($urandom_range(0, 3));
        accept_cmd({op, hb, 4'(sq)});
        turn_exit(1'b0);
        ramp_finish(0, int'($urandom_range(3, 24)), 1'b0, sq, 1'b1, 1'b0, 16'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
